mem_responder: RTL and testbench

- Memory-side responder for the core's instruction-fetch and data-access requests.
- Serves three request types over a valid/ready handshake against a byte-addressed, little-endian RAM of DEPTH bytes:
  - 10-byte instruction fetch
  - 8-byte data read
  - 8-byte data write
- Returns results on a separate registered response channel after a programmable access latency, and flags out-of-range or illegal requests.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response channel between the core-side requester and mem_responder.
// Signal names keep the responder's point of view (_i into it, _o out of it).
interface mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_type_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic [79:0] rsp_instr_o;
  logic        rsp_error_o;

  modport master (
    output req_valid_i, req_type_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_instr_o, rsp_error_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_instr_o, rsp_error_o
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed little-endian RAM serving 8-byte data reads/writes and 10-byte
// instruction fetches, one request at a time, with a fixed access latency.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [63:0]   DATA_MAX  = 64'(DEPTH - 8);
  localparam logic [63:0]   FETCH_MAX = 64'(DEPTH - 10);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    REQ_READ    = 2'b00,
    REQ_WRITE   = 2'b01,
    REQ_FETCH   = 2'b10,
    REQ_ILLEGAL = 2'b11
  } req_type_e;

  logic [7:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_type_e   type_q, type_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [79:0] rsp_instr_q, rsp_instr_d;
  logic        rsp_error_q, rsp_error_d;

  logic          mem_we;
  logic [AW-1:0] base;
  logic [79:0]   rd_window;
  logic          data_ok;
  logic          fetch_ok;

  // Range checks use the full 64-bit address so huge addresses never alias.
  assign base     = addr_q[AW-1:0];
  assign data_ok  = (addr_q <= DATA_MAX);
  assign fetch_ok = (addr_q <= FETCH_MAX);

  always_comb begin
    rd_window = '0;
    for (int k = 0; k < 10; k++) begin
      rd_window[8*k +: 8] = mem_q[base + AW'(k)];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_instr_d = rsp_instr_q;
    rsp_error_d = rsp_error_q;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          type_d  = req_type_e'(bus.req_type_i);
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_instr_d = '0;
          rsp_error_d = 1'b0;
          state_d     = RESP;
          // Illegal requests respond with zero data and leave memory untouched.
          unique case (type_q)
            REQ_READ: begin
              if (data_ok) rsp_rdata_d = rd_window[63:0];
              else         rsp_error_d = 1'b1;
            end
            REQ_WRITE: begin
              if (data_ok) mem_we      = 1'b1;
              else         rsp_error_d = 1'b1;
            end
            REQ_FETCH: begin
              if (fetch_ok) rsp_instr_d = rd_window;
              else          rsp_error_d = 1'b1;
            end
            default: rsp_error_d = 1'b1;
          endcase
        end
      end

      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_instr_d = '0;
          rsp_error_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= REQ_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_instr_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Memory has no reset; mem_we derives from the reset state register, so a
  // reset during ACCESS drops the pending write.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[base + AW'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_instr_o = rsp_instr_q;
  assign bus.rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model predicts every
// response, backed by directed literal checks and a LATENCY=1 throughput check.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_responder_if bus ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_lat1 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus1)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic [79:0] instr;
    logic        err;
    logic        wr;
    logic [63:0] waddr;
    logic [63:0] wdata;
  } rsp_t;

  int tests  = 0;
  int failed = 0;

  logic [7:0] ref_mem [DEPTH];
  bit          pend;
  longint      edge_n;
  longint      acc_edge;
  rsp_t        exp_rsp;
  int          n_acc;
  int          n_rsp;
  logic        exp_valid;
  logic [63:0] last_rdata;
  logic [79:0] last_instr;
  logic        last_err;

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // What a request must return, judged purely from address range and memory contents.
  function automatic rsp_t predict(input logic [1:0] t, input logic [63:0] a, input logic [63:0] wd);
    rsp_t r;
    int   b;
    r       = '0;
    r.waddr = a;
    r.wdata = wd;
    b       = int'(a[31:0]);
    case (t)
      2'b00: if (a <= 64'(DEPTH - 8)) for (int k = 0; k < 8; k++) r.rdata[8*k +: 8] = ref_mem[b + k];
             else r.err = 1'b1;
      2'b01: if (a <= 64'(DEPTH - 8)) r.wr = 1'b1;
             else r.err = 1'b1;
      2'b10: if (a <= 64'(DEPTH - 10)) for (int k = 0; k < 10; k++) r.instr[8*k +: 8] = ref_mem[b + k];
             else r.err = 1'b1;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r < 6) return 64'($urandom_range(0, DEPTH - 1));
    if (r < 8) return 64'(DEPTH - 24 + int'($urandom_range(0, 23)));
    if (r < 9) return {$urandom, $urandom};
    return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
  endfunction

  // Model: one request outstanding; response valid LAT edges after acceptance,
  // write commits on that same edge, handshake frees the slot for the next edge.
  initial begin
    pend = 0; edge_n = 0; acc_edge = 0; n_acc = 0; n_rsp = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend = 0;
      end else begin
        edge_n++;
        if (!pend) begin
          if (bus.req_valid_i === 1'b1) begin
            exp_rsp  = predict(bus.req_type_i, bus.req_addr_i, bus.req_wdata_i);
            pend     = 1;
            acc_edge = edge_n;
            n_acc++;
          end
        end else if (edge_n == acc_edge + LAT) begin
          if (exp_rsp.wr)
            for (int k = 0; k < 8; k++) ref_mem[int'(exp_rsp.waddr[31:0]) + k] = exp_rsp.wdata[8*k +: 8];
        end else if (edge_n > acc_edge + LAT && bus.rsp_ready_i === 1'b1) begin
          pend = 0;
          n_rsp++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      exp_valid = pend && (edge_n >= acc_edge + LAT);
      checkOutput("req_ready", bus.req_ready_o, !pend);
      checkOutput("rsp_valid", bus.rsp_valid_o, exp_valid);
      if (exp_valid) begin
        checkOutput("rsp_rdata", bus.rsp_rdata_o, exp_rsp.rdata);
        checkOutput("rsp_instr", bus.rsp_instr_o, exp_rsp.instr);
        checkOutput("rsp_error", bus.rsp_error_o, exp_rsp.err);
        last_rdata = bus.rsp_rdata_o;
        last_instr = bus.rsp_instr_o;
        last_err   = bus.rsp_error_o;
      end else begin
        checkOutput("idle_rdata", bus.rsp_rdata_o, '0);
        checkOutput("idle_instr", bus.rsp_instr_o, '0);
        checkOutput("idle_error", bus.rsp_error_o, '0);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] t, input logic [63:0] a, input logic [63:0] wd);
    int guard;
    int start;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_type_i  = t;
    bus.req_addr_i  = a;
    bus.req_wdata_i = wd;
    bus.rsp_ready_i = 1'b1;
    start = n_acc;
    guard = 0;
    while (n_acc == start && guard < 20) begin @(negedge clk); guard++; end
    bus.req_valid_i = 1'b0;
    if (n_acc == start) begin
      tests++; failed++;
      $display("[TB] FAIL accept_timeout: got no acceptance, expected one within 20 cycles");
      return;
    end
    start = n_rsp;
    guard = 0;
    while (n_rsp == start && guard < 20) begin @(negedge clk); guard++; end
    if (n_rsp == start) begin
      tests++; failed++;
      $display("[TB] FAIL response_timeout: got no handshake, expected one within 20 cycles");
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected one before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] wd0, wd1;
    logic [1:0]  t1 [5];
    logic [63:0] a1 [5];
    logic [63:0] w1 [5];
    logic [63:0] er [5];
    logic [79:0] ei [5];
    int guard;

    bus.req_valid_i  = 1'b0; bus.req_type_i  = '0; bus.req_addr_i  = '0;
    bus.req_wdata_i  = '0;   bus.rsp_ready_i = 1'b1;
    bus1.req_valid_i = 1'b0; bus1.req_type_i = '0; bus1.req_addr_i = '0;
    bus1.req_wdata_i = '0;   bus1.rsp_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", bus.req_ready_o, 1'b1);
    checkOutput("reset_valid", bus.rsp_valid_o, 1'b0);
    checkOutput("reset_rdata", bus.rsp_rdata_o, '0);
    checkOutput("reset_instr", bus.rsp_instr_o, '0);
    checkOutput("reset_error", bus.rsp_error_o, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH / 8; i++) applyStimulus(2'b01, 64'(i * 8), {$urandom, $urandom});

    applyStimulus(2'b01, 64'h10, 64'h1122_3344_5566_7788);
    checkOutput("wr10_error", last_err, 1'b0);
    applyStimulus(2'b01, 64'h18, 64'h0);
    applyStimulus(2'b00, 64'h10, 64'h0);
    checkOutput("rd10", last_rdata, 64'h1122_3344_5566_7788);
    applyStimulus(2'b00, 64'h13, 64'h0);
    checkOutput("rd13_unaligned", last_rdata, 64'h0000_0011_2233_4455);

    applyStimulus(2'b01, 64'h20, 64'h0000_0000_0008_F230);
    applyStimulus(2'b01, 64'h28, 64'h0);
    applyStimulus(2'b10, 64'h20, 64'h0);
    checkOutput("fetch20_instr", last_instr, 80'h0000_0000_0000_0008_F230);
    checkOutput("fetch20_rdata", last_rdata, 64'h0);

    applyStimulus(2'b01, 64'd1016, 64'hA5A5_5A5A_0F0F_F0F0);
    applyStimulus(2'b00, 64'd1016, 64'h0);
    checkOutput("rd1016", last_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
    checkOutput("rd1016_error", last_err, 1'b0);
    applyStimulus(2'b00, 64'd1017, 64'h0);
    checkOutput("rd1017_error", last_err, 1'b1);
    checkOutput("rd1017_rdata", last_rdata, 64'h0);
    applyStimulus(2'b10, 64'd1014, 64'h0);
    checkOutput("fetch1014_error", last_err, 1'b0);
    applyStimulus(2'b10, 64'd1015, 64'h0);
    checkOutput("fetch1015_error", last_err, 1'b1);
    checkOutput("fetch1015_instr", last_instr, 80'h0);
    applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
    checkOutput("rd_huge_error", last_err, 1'b1);
    applyStimulus(2'b01, 64'd1020, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("wr1020_error", last_err, 1'b1);
    applyStimulus(2'b00, 64'd1016, 64'h0);
    checkOutput("rd1016_after_bad_wr", last_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
    applyStimulus(2'b11, 64'h0, 64'h0);
    checkOutput("type11_error", last_err, 1'b1);

    // Response held under backpressure, then released.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_type_i = 2'b00; bus.req_addr_i = 64'h10; bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    guard = 0;
    while (!(pend && edge_n >= acc_edge + LAT) && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", bus.rsp_valid_o, 1'b1);
      checkOutput("bp_ready", bus.req_ready_o, 1'b0);
      checkOutput("bp_rdata", bus.rsp_rdata_o, 64'h1122_3344_5566_7788);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", bus.rsp_valid_o, 1'b0);
    checkOutput("bp_release_ready", bus.req_ready_o, 1'b1);

    // Reset while a write is still in ACCESS must drop it.
    applyStimulus(2'b01, 64'h40, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_type_i = 2'b01; bus.req_addr_i = 64'h40; bus.req_wdata_i = 64'hDEAD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", bus.req_ready_o, 1'b1);
    checkOutput("midrst_valid", bus.rsp_valid_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 64'h40, 64'h0);
    checkOutput("midrst_rd40", last_rdata, 64'h0123_4567_89AB_CDEF);

    // LATENCY=1 instance: request held high, one transaction every 3 cycles.
    wd0 = {$urandom, $urandom};
    wd1 = {$urandom, $urandom};
    t1[0] = 2'b01; a1[0] = 64'h80; w1[0] = wd0; er[0] = '0;                     ei[0] = '0;
    t1[1] = 2'b01; a1[1] = 64'h88; w1[1] = wd1; er[1] = '0;                     ei[1] = '0;
    t1[2] = 2'b00; a1[2] = 64'h80; w1[2] = '0;  er[2] = wd0;                    ei[2] = '0;
    t1[3] = 2'b10; a1[3] = 64'h80; w1[3] = '0;  er[3] = '0;                     ei[3] = {wd1[15:0], wd0};
    t1[4] = 2'b00; a1[4] = 64'h84; w1[4] = '0;  er[4] = {wd1[31:0], wd0[63:32]}; ei[4] = '0;
    @(negedge clk);
    bus1.rsp_ready_i = 1'b1;
    bus1.req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus1.req_type_i  = t1[i];
      bus1.req_addr_i  = a1[i];
      bus1.req_wdata_i = w1[i];
      @(negedge clk);
      checkOutput("lat1_accept_ready", bus1.req_ready_o, 1'b0);
      checkOutput("lat1_accept_valid", bus1.rsp_valid_o, 1'b0);
      @(negedge clk);
      checkOutput("lat1_rsp_valid", bus1.rsp_valid_o, 1'b1);
      checkOutput("lat1_rsp_rdata", bus1.rsp_rdata_o, er[i]);
      checkOutput("lat1_rsp_instr", bus1.rsp_instr_o, ei[i]);
      checkOutput("lat1_rsp_error", bus1.rsp_error_o, 1'b0);
      @(negedge clk);
      checkOutput("lat1_done_valid", bus1.rsp_valid_o, 1'b0);
      checkOutput("lat1_done_ready", bus1.req_ready_o, 1'b1);
    end
    bus1.req_valid_i = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.req_valid_i = ($urandom_range(0, 99) < 60);
      bus.req_type_i  = 2'($urandom_range(0, 3));
      bus.req_addr_i  = rand_addr();
      bus.req_wdata_i = {$urandom, $urandom};
      bus.rsp_ready_i = ($urandom_range(0, 99) < 70);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
